// File: rtl/avr_io_arbiter.sv
// Round-robin arbiter sharing the single-master AVR IO bus between two requesters,
// with bounded lock support for atomic read-modify-write sequences.
module avr_io_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LOCK   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] io_addr,
    inout  logic [DATA_WIDTH-1:0] io_data,
    output logic                  io_read,
    output logic                  io_write
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [3:0] MAX_LOCK_V = 4'(MAX_LOCK);

    logic [1:0]            state;
    logic                  owner;
    logic                  last_owner;
    logic                  we_q;
    logic                  lock_q;
    logic [3:0]            lock_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    logic owner_req;
    logic other_req;
    logic keep_lock;
    logic rr_last;
    logic arb_valid;
    logic arb_sel;

    // In RESP the owner becomes last_owner at this same edge, so it is the round-robin reference.
    always_comb begin
        owner_req = owner ? m1_req : m0_req;
        other_req = owner ? m0_req : m1_req;
        rr_last   = (state == RESP) ? owner : last_owner;
        keep_lock = (state == RESP) && lock_q && owner_req &&
                    (!other_req || (lock_cnt < MAX_LOCK_V));
        arb_valid = 1'b0;
        arb_sel   = 1'b0;
        if (keep_lock) begin
            arb_valid = 1'b1;
            arb_sel   = owner;
        end else if (m0_req && m1_req) begin
            arb_valid = 1'b1;
            arb_sel   = ~rr_last;
        end else if (m0_req) begin
            arb_valid = 1'b1;
            arb_sel   = 1'b0;
        end else if (m1_req) begin
            arb_valid = 1'b1;
            arb_sel   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            we_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_cnt   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (state == RESP) begin
                        last_owner <= owner;
                    end
                    if (arb_valid) begin
                        state   <= ACCESS;
                        owner   <= arb_sel;
                        addr_q  <= arb_sel ? m1_addr  : m0_addr;
                        wdata_q <= arb_sel ? m1_wdata : m0_wdata;
                        we_q    <= arb_sel ? m1_we    : m0_we;
                        lock_q  <= arb_sel ? m1_lock  : m0_lock;
                        if (keep_lock) begin
                            lock_cnt <= (lock_cnt == 4'hF) ? lock_cnt : lock_cnt + 4'd1;
                        end else begin
                            lock_cnt <= '0;
                        end
                    end else begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (owner) begin
                            rdata1_q <= io_data;
                        end else begin
                            rdata0_q <= io_data;
                        end
                    end
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_gnt   = (state != IDLE) && !owner;
    assign m1_gnt   = (state != IDLE) &&  owner;
    assign m0_ack   = (state == RESP) && !owner;
    assign m1_ack   = (state == RESP) &&  owner;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign io_addr  = addr_q;
    assign io_read  = (state == ACCESS) && !we_q;
    assign io_write = (state == ACCESS) &&  we_q;
    assign io_data  = io_write ? wdata_q : 'z;

endmodule

// File: tb/tb_avr_io_arbiter.sv
// Directed bench for avr_io_arbiter: per-master command queues act as the scoreboard,
// a simple peripheral answers reads with addr ^ 0x4C.
module tb_avr_io_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
    logic [5:0] m0_addr = '0;
    logic [7:0] m0_wdata = '0;
    logic       m0_gnt, m0_ack;
    logic [7:0] m0_rdata;
    logic       m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [5:0] m1_addr = '0;
    logic [7:0] m1_wdata = '0;
    logic       m1_gnt, m1_ack;
    logic [7:0] m1_rdata;
    logic [5:0] io_addr;
    wire  [7:0] io_data;
    logic       io_read, io_write;

    always #5 clk = ~clk;

    assign io_data = io_read ? ({2'b00, io_addr} ^ 8'h4C) : 8'bz;

    avr_io_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .io_addr(io_addr), .io_data(io_data), .io_read(io_read), .io_write(io_write)
    );

    typedef struct {
        logic       we;
        logic       lock;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } cmd_t;

    cmd_t       q0[$];
    cmd_t       q1[$];
    int         gnt_log[$];
    int         acc_cyc[$];
    logic [7:0] model_rd0 = '0;
    logic [7:0] model_rd1 = '0;
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         ack0_cnt = 0;
    int         ack1_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (q0.size() > 0) begin
            m0_req = 1'b1; m0_we = q0[0].we; m0_lock = q0[0].lock;
            m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
        end else begin
            m0_req = 1'b0;
        end
        if (q1.size() > 0) begin
            m1_req = 1'b1; m1_we = q1[0].we; m1_lock = q1[0].lock;
            m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
        end else begin
            m1_req = 1'b0;
        end
    endtask

    task automatic push(input int m, input logic we, input logic lock,
                        input logic [5:0] addr, input logic [7:0] wdata);
        cmd_t c;
        c.we = we; c.lock = lock; c.addr = addr; c.wdata = wdata;
        if (m == 0) begin
            if (!we) model_rd0 = {2'b00, addr} ^ 8'h4C;
            c.exp_rdata = model_rd0;
            q0.push_back(c);
        end else begin
            if (!we) model_rd1 = {2'b00, addr} ^ 8'h4C;
            c.exp_rdata = model_rd1;
            q1.push_back(c);
        end
        drive();
    endtask

    task automatic tick();
        int   owner;
        cmd_t f;
        @(posedge clk);
        #1;
        cyc++;
        check("rd_wr_exclusive", 32'(io_read && io_write), 32'd0);
        check("single_gnt", 32'(m0_gnt && m1_gnt), 32'd0);
        check("ack_implies_gnt", 32'((m0_ack && !m0_gnt) || (m1_ack && !m1_gnt)), 32'd0);
        if (io_read || io_write) begin
            owner = m1_gnt ? 1 : 0;
            gnt_log.push_back(owner);
            acc_cyc.push_back(cyc);
            check("gnt_in_access", 32'(m0_gnt || m1_gnt), 32'd1);
            check("access_has_cmd", 32'(owner ? q1.size() : q0.size()) != 0 ? 32'd1 : 32'd0, 32'd1);
            if ((owner ? q1.size() : q0.size()) > 0) begin
                f = owner ? q1[0] : q0[0];
                check("io_addr", 32'(io_addr), 32'(f.addr));
                check("io_write_dir", 32'(io_write), 32'(f.we));
                if (f.we) check("io_wdata", 32'(io_data), 32'(f.wdata));
            end
        end
        if (m0_ack) begin
            ack0_cnt++;
            check("m0_ack_pending", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                check("m0_rdata", 32'(m0_rdata), 32'(q0[0].exp_rdata));
                void'(q0.pop_front());
            end
        end
        if (m1_ack) begin
            ack1_cnt++;
            check("m1_ack_pending", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                check("m1_rdata", 32'(m1_rdata), 32'(q1[0].exp_rdata));
                void'(q1.pop_front());
            end
        end
        drive();
    endtask

    task automatic run_until_done(input string tag, input int max);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m0_gnt || m1_gnt) && n < max) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < max), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q0.delete(); q1.delete();
        drive();
        model_rd0 = '0; model_rd1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
        check("rst_ack", 32'({m0_ack, m1_ack}), 32'd0);
        check("rst_strobes", 32'({io_read, io_write}), 32'd0);
        check("rst_io_addr", 32'(io_addr), 32'd0);
        check("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
        rst = 1'b1;
        gnt_log.delete(); acc_cyc.delete();
        ack0_cnt = 0; ack1_cnt = 0;
    endtask

    initial begin
        do_reset();

        // single read from m0
        push(0, 1'b0, 1'b0, 6'd22, 8'h00);
        tick();
        check("rd_strobe", 32'(io_read), 32'd1);
        check("rd_addr", 32'(io_addr), 32'd22);
        check("rd_no_early_ack", 32'(m0_ack), 32'd0);
        check("rd_m1_idle", 32'({m1_gnt, m1_ack}), 32'd0);
        tick();
        check("rd_ack", 32'(m0_ack), 32'd1);
        check("rd_strobe_1cyc", 32'(io_read), 32'd0);
        check("rd_value", 32'(m0_rdata), 32'h5A);
        check("rd_m1_ack", 32'(m1_ack), 32'd0);
        tick();
        check("rd_ack_pulse", 32'({m0_ack, m0_gnt}), 32'd0);

        // single write from m1
        push(1, 1'b1, 1'b0, 6'd23, 8'h3C);
        tick();
        check("wr_strobe", 32'(io_write), 32'd1);
        check("wr_data", 32'(io_data), 32'h3C);
        check("wr_no_read", 32'(io_read), 32'd0);
        tick();
        check("wr_ack", 32'(m1_ack), 32'd1);
        check("wr_strobe_1cyc", 32'(io_write), 32'd0);
        repeat (3) tick();
        check("wr_ack_once", 32'(ack1_cnt), 32'd1);
        check("wr_rdata_kept", 32'(m1_rdata), 32'd0);

        // contention: strict alternation, one transaction every 2 cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 1'b0, 6'(i + 1), 8'h00);
            push(1, 1'b0, 1'b0, 6'(i + 10), 8'h00);
        end
        run_until_done("contention", 100);
        check("cont_count", 32'(gnt_log.size()), 32'd8);
        for (int i = 0; i < gnt_log.size(); i++)
            check("cont_order", 32'(gnt_log[i]), 32'(i % 2));
        for (int i = 1; i < acc_cyc.size(); i++)
            check("cont_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);

        // atomic read-modify-write on addr 22 by m0 while m1 waits
        do_reset();
        push(0, 1'b0, 1'b1, 6'd22, 8'h00);
        push(0, 1'b1, 1'b0, 6'd22, 8'h5B);
        push(1, 1'b1, 1'b0, 6'd23, 8'h77);
        run_until_done("rmw", 100);
        check("rmw_count", 32'(gnt_log.size()), 32'd3);
        if (gnt_log.size() == 3) begin
            check("rmw_first", 32'(gnt_log[0]), 32'd0);
            check("rmw_second", 32'(gnt_log[1]), 32'd0);
            check("rmw_third", 32'(gnt_log[2]), 32'd1);
        end

        // lock bound: m1 gets in after 5 locked m0 transactions
        do_reset();
        for (int i = 0; i < 7; i++) push(0, 1'b0, 1'b1, 6'(30 + i), 8'h00);
        for (int i = 0; i < 2; i++) push(1, 1'b0, 1'b0, 6'(40 + i), 8'h00);
        run_until_done("lockbound", 200);
        begin
            int exp_log[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
            check("lock_count", 32'(gnt_log.size()), 32'd9);
            for (int i = 0; i < 9 && i < gnt_log.size(); i++)
                check("lock_order", 32'(gnt_log[i]), 32'(exp_log[i]));
        end

        // reset asserted during an ACCESS write
        do_reset();
        push(1, 1'b1, 1'b0, 6'd23, 8'h3C);
        tick();
        check("mid_wr_strobe", 32'(io_write), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_async_write", 32'(io_write), 32'd0);
        check("mid_async_read", 32'(io_read), 32'd0);
        check("mid_async_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
        q0.delete(); q1.delete();
        drive();
        @(posedge clk);
        #1;
        check("mid_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
        rst = 1'b1;
        gnt_log.delete(); acc_cyc.delete();
        ack0_cnt = 0; ack1_cnt = 0;
        push(0, 1'b0, 1'b0, 6'd5, 8'h00);
        push(1, 1'b0, 1'b0, 6'd6, 8'h00);
        run_until_done("post_reset", 100);
        check("post_count", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() == 2) begin
            check("post_tie_m0", 32'(gnt_log[0]), 32'd0);
            check("post_then_m1", 32'(gnt_log[1]), 32'd1);
        end
        check("post_acks", 32'(ack0_cnt + ack1_cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
